// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host transmitter: FSM state codes,
// frame geometry, default timing and small frame helpers.
package ps2_pkg;

   // Default timing at a 50 MHz system clock.
   localparam int INHIBIT_CYCLES_DEF = 5000;    // 100 us clock-low inhibit
   localparam int TIMEOUT_CYCLES_DEF = 750000;  // 15 ms frame watchdog

   // Bits driven by the host after the start bit: 8 data, parity, stop.
   localparam logic [3:0] FRAME_BITS = 4'd10;
   localparam logic [3:0] LAST_BIT   = FRAME_BITS - 4'd1;

   // FSM state codes.
   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_INHIBIT   = 3'd1;
   localparam logic [2:0] ST_START     = 3'd2;
   localparam logic [2:0] ST_SHIFT     = 3'd3;
   localparam logic [2:0] ST_ACK       = 3'd4;
   localparam logic [2:0] ST_WAIT_IDLE = 3'd5;

   // Odd parity: the parity bit makes the total count of ones odd.
   function automatic logic odd_parity(input logic [7:0] data);
      return ~^data;
   endfunction

   // Bit idx of the host-driven frame {stop, parity, data[7:0]}.
   function automatic logic frame_bit(input logic [9:0] frame, input logic [3:0] idx);
      return frame[idx];
   endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for an asynchronous PS/2 line plus a falling-edge
// strobe. Flops reset to 1 (the idle level of an open-drain line) so that
// leaving reset never produces a spurious falling edge.
module ps2_sync_edge (
   input  logic clock,
   input  logic reset,
   input  logic i_async,
   output logic o_sync,
   output logic o_fall
);

   logic r_meta;
   logic r_sync;
   logic r_prev;

   // Synchronizer chain plus one delayed copy for edge detection.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_meta <= 1'b1;
         r_sync <= 1'b1;
         r_prev <= 1'b1;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
         r_prev <= r_sync;
      end
   end

   assign o_sync = r_sync;
   assign o_fall = r_prev & ~r_sync;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | lines released, tx_ready high, waiting for a request
// INHIBIT   | clock held low INHIBIT_CYCLES; data pulled low in last cycle
// START     | clock released, start bit (data low) held until first fall
// SHIFT     | one bit per device fall: data LSB first, parity, stop
// ACK       | lines released; next fall samples the device ACK on data
// WAIT_IDLE | wait for clock and data both high, then report done
//
// Optional build macro PS2_TX_TIMEOUT_EN adds a frame watchdog that aborts
// the frame TIMEOUT_CYCLES after entering START.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYCLES = INHIBIT_CYCLES_DEF,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   output logic       tx_done,
   output logic       tx_error
);

   localparam int            IW       = $clog2(INHIBIT_CYCLES + 1);
   localparam logic [IW-1:0] INH_LOAD = IW'(INHIBIT_CYCLES - 1);
   localparam logic          INH_ONE  = (INHIBIT_CYCLES == 1);

   if (INHIBIT_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("ps2_host_tx: INHIBIT_CYCLES and TIMEOUT_CYCLES must be at least 1");
   end

   logic          w_clk_sync;
   logic          w_clk_fall;
   logic          w_data_sync;
   logic          w_unused_data_fall;

   logic [2:0]    r_state;
   logic [9:0]    r_shift;
   logic [3:0]    r_bit_cnt;
   logic [IW-1:0] r_inh_cnt;
   logic          r_clk_oe;
   logic          r_data_oe;
   logic          r_ready;
   logic          r_done;
   logic          r_error;

`ifdef PS2_TX_TIMEOUT_EN
   localparam int            WW       = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WW-1:0] WDG_LOAD = WW'(TIMEOUT_CYCLES - 1);
   logic [WW-1:0] r_wdog;
`endif

   ps2_sync_edge u_clk_sync (
      .clock   (clock),
      .reset   (reset),
      .i_async (ps2_clk_in),
      .o_sync  (w_clk_sync),
      .o_fall  (w_clk_fall)
   );

   ps2_sync_edge u_data_sync (
      .clock   (clock),
      .reset   (reset),
      .i_async (ps2_data_in),
      .o_sync  (w_data_sync),
      .o_fall  (w_unused_data_fall)
   );

   // Frame sequencer; every output is a register updated here.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_shift   <= '0;
         r_bit_cnt <= '0;
         r_inh_cnt <= '0;
         r_clk_oe  <= 1'b0;
         r_data_oe <= 1'b0;
         r_ready   <= 1'b1;
         r_done    <= 1'b0;
         r_error   <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
         r_wdog    <= '0;
`endif
      end else begin
         r_done  <= 1'b0;
         r_error <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (tx_valid && r_ready) begin
                  r_shift   <= {1'b1, odd_parity(tx_data), tx_data};
                  r_bit_cnt <= '0;
                  r_inh_cnt <= INH_LOAD;
                  r_clk_oe  <= 1'b1;
                  r_data_oe <= INH_ONE;
                  r_ready   <= 1'b0;
                  r_state   <= ST_INHIBIT;
               end
            end
            ST_INHIBIT: begin
               if (r_inh_cnt == '0) begin
                  r_clk_oe  <= 1'b0;
                  r_data_oe <= 1'b1;
                  r_state   <= ST_START;
`ifdef PS2_TX_TIMEOUT_EN
                  r_wdog    <= WDG_LOAD;
`endif
               end else begin
                  r_inh_cnt <= r_inh_cnt - IW'(1);
                  r_data_oe <= (r_inh_cnt == IW'(1));
               end
            end
            ST_START: begin
               if (w_clk_fall) begin
                  r_data_oe <= ~frame_bit(r_shift, 4'd0);
                  r_state   <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (w_clk_fall) begin
                  if (r_bit_cnt == LAST_BIT) begin
                     r_data_oe <= 1'b0;
                     r_state   <= ST_ACK;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 4'd1;
                     r_data_oe <= ~frame_bit(r_shift, r_bit_cnt + 4'd1);
                  end
               end
            end
            ST_ACK: begin
               r_data_oe <= 1'b0;
               if (w_clk_fall) begin
                  if (!w_data_sync) begin
                     r_state <= ST_WAIT_IDLE;
                  end else begin
                     r_error <= 1'b1;
                     r_ready <= 1'b1;
                     r_state <= ST_IDLE;
                  end
               end
            end
            ST_WAIT_IDLE: begin
               if (w_clk_sync && w_data_sync) begin
                  r_done  <= 1'b1;
                  r_ready <= 1'b1;
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_clk_oe  <= 1'b0;
               r_data_oe <= 1'b0;
               r_ready   <= 1'b1;
               r_state   <= ST_IDLE;
            end
         endcase

`ifdef PS2_TX_TIMEOUT_EN
         // Watchdog overrides whatever the sequencer decided this cycle.
         if (r_state == ST_START || r_state == ST_SHIFT ||
             r_state == ST_ACK   || r_state == ST_WAIT_IDLE) begin
            if (r_wdog == '0) begin
               r_done    <= 1'b0;
               r_error   <= 1'b1;
               r_ready   <= 1'b1;
               r_clk_oe  <= 1'b0;
               r_data_oe <= 1'b0;
               r_state   <= ST_IDLE;
            end else begin
               r_wdog <= r_wdog - WW'(1);
            end
         end
`endif
      end
   end

   assign tx_ready    = r_ready;
   assign ps2_clk_oe  = r_clk_oe;
   assign ps2_data_oe = r_data_oe;
   assign tx_done     = r_done;
   assign tx_error    = r_error;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Testbench for ps2_host_tx: a PS/2 device model clocks frames out of the
// host, records the bits seen on the data line and compares them with a
// frame computed arithmetically from the byte sent.
module tb_ps2_host_tx;

   localparam int INH = 40;
   localparam int TMO = 3000;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic       ps2_clk_oe;
   logic       ps2_data_oe;
   logic       tx_done;
   logic       tx_error;
   logic       dev_clk = 1'b1;
   logic       dev_data_low = 1'b0;
   wire        ps2_clk_in  = dev_clk & ~ps2_clk_oe;
   wire        ps2_data_in = ~dev_data_low & ~ps2_data_oe;

   ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
      .clock       (clock),
      .reset       (reset),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .ps2_clk_in  (ps2_clk_in),
      .ps2_data_in (ps2_data_in),
      .ps2_clk_oe  (ps2_clk_oe),
      .ps2_data_oe (ps2_data_oe),
      .tx_done     (tx_done),
      .tx_error    (tx_error)
   );

   always #5 clock = ~clock;

   int n_tests = 0;
   int n_fail  = 0;
   int dev_half = 10;

   task automatic chk(input string name, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   // Line frame as seen by the device: bit 0 start, 1..8 data LSB first,
   // 9 odd parity, 10 stop.
   function automatic logic [10:0] model_frame(input logic [7:0] d);
      logic [10:0] f;
      int ones;
      ones = 0;
      f[0] = 1'b0;
      for (int i = 0; i < 8; i++) begin
         f[i+1] = d[i];
         ones += int'(d[i]);
      end
      f[9]  = (ones % 2 == 0);
      f[10] = 1'b1;
      return f;
   endfunction

   // Monitor: pulse counts, inhibit measurements, timing marks.
   int   cyc = 0, done_cnt = 0, err_cnt = 0, pulse_viol = 0;
   int   inh_run = 0, inh_data_run = 0, inh_total = 0;
   int   last_inh_len = 0, last_inh_data = 0, last_inh_data_last = 0;
   int   start_cyc = 0, err_cyc = 0;
   logic prev_clk_oe = 1'b0, prev_data_oe = 1'b0, prev_ready = 1'b1;

   always @(posedge clock) begin
      #1;
      cyc++;
      if (tx_done) done_cnt++;
      if (tx_error) begin
         err_cnt++;
         err_cyc = cyc;
      end
      if ((tx_done || tx_error) && !(tx_ready && !prev_ready)) pulse_viol++;
      if (ps2_clk_oe) begin
         inh_run++;
         inh_total++;
         if (ps2_data_oe) inh_data_run++;
      end else if (prev_clk_oe) begin
         last_inh_len       = inh_run;
         last_inh_data      = inh_data_run;
         last_inh_data_last = int'(prev_data_oe);
         inh_run            = 0;
         inh_data_run       = 0;
         if (ps2_data_oe) start_cyc = cyc;
      end
      prev_clk_oe  = ps2_clk_oe;
      prev_data_oe = ps2_data_oe;
      prev_ready   = tx_ready;
   end

   task automatic send(input logic [7:0] d);
      int w;
      w = 0;
      while (!tx_ready && w < 2000) begin
         @(negedge clock);
         w++;
      end
      @(negedge clock);
      tx_data  = d;
      tx_valid = 1'b1;
      @(negedge clock);
      tx_valid = 1'b0;
      chk("accept_ready_low", int'(tx_ready), 0);
   endtask

   // Device model: waits for the start bit, then generates up to nfall
   // falling edges, sampling each host bit before the following rise.
   task automatic device(input int nfall, input bit ack, input int h,
                         output logic [10:0] frame);
      int w;
      frame = '0;
      w = 0;
      while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && w < 400) begin
         @(negedge clock);
         w++;
      end
      if (w >= 400) begin
         chk("start_wait", 0, 1);
         return;
      end
      repeat (5) @(negedge clock);
      frame[0] = ps2_data_in;
      for (int k = 1; k <= nfall && k <= 12; k++) begin
         dev_clk = 1'b0;
         if (k == 11) begin
            repeat (h / 2) @(negedge clock);
            dev_data_low = ack;
            repeat (h - h / 2) @(negedge clock);
         end else begin
            repeat (h) @(negedge clock);
         end
         if (k <= 10) frame[k] = ps2_data_in;
         dev_clk = 1'b1;
         repeat (h) @(negedge clock);
         if (k == 12) dev_data_low = 1'b0;
      end
   endtask

   typedef struct {
      logic [7:0]  data;
      bit          ack;
      bit          poke;
      int          exp_done;
      int          exp_err;
      logic [10:0] exp_frame;
   } vec_t;

   task automatic run_frame(input vec_t v, input string tag);
      int d0, e0, t0, w;
      logic [10:0] fr;
      d0 = done_cnt;
      e0 = err_cnt;
      send(v.data);
      if (v.poke) begin
         repeat (10) @(negedge clock);
         tx_data  = 8'hAA;
         tx_valid = 1'b1;
         repeat (3) @(negedge clock);
         tx_valid = 1'b0;
      end
      device(12, v.ack, dev_half, fr);
      w = 0;
      while (done_cnt == d0 && err_cnt == e0 && w < 200) begin
         @(negedge clock);
         w++;
      end
      repeat (3) @(negedge clock);
      chk({tag, "_frame"}, int'(fr), int'(v.exp_frame));
      chk({tag, "_done"}, done_cnt - d0, v.exp_done);
      chk({tag, "_error"}, err_cnt - e0, v.exp_err);
      chk({tag, "_inhibit_len"}, last_inh_len, INH);
      chk({tag, "_inhibit_data"}, last_inh_data * 2 + last_inh_data_last, 3);
      chk({tag, "_idle_lines"}, int'({tx_ready, ps2_clk_oe, ps2_data_oe}), 3'b100);
      if (v.poke) begin
         t0 = inh_total;
         repeat (100) @(negedge clock);
         chk({tag, "_no_second_frame"}, inh_total - t0, 0);
      end
   endtask

   vec_t vecs[5];

   initial begin
      int d0, e0, w;
      logic [10:0] fr;
      vec_t rv;

      vecs[0] = '{8'hED, 1'b1, 1'b0, 1, 0, {1'b1, 1'b1, 8'hED, 1'b0}};
      vecs[1] = '{8'h00, 1'b1, 1'b0, 1, 0, {1'b1, 1'b1, 8'h00, 1'b0}};
      vecs[2] = '{8'h5A, 1'b0, 1'b0, 0, 1, {1'b1, 1'b1, 8'h5A, 1'b0}};
      vecs[3] = '{8'h96, 1'b1, 1'b1, 1, 0, {1'b1, 1'b1, 8'h96, 1'b0}};
      vecs[4] = '{8'h80, 1'b1, 1'b0, 1, 0, {1'b1, 1'b0, 8'h80, 1'b0}};

      repeat (3) @(negedge clock);
      chk("reset_state", int'({tx_ready, ps2_clk_oe, ps2_data_oe, tx_done, tx_error}), 5'b10000);
      reset = 1'b0;
      repeat (5) @(negedge clock);

      for (int i = 0; i < 5; i++) begin
         dev_half = 10;
         run_frame(vecs[i], $sformatf("vec%0d", i));
      end

      // Reset while the host is driving data bit 4.
      d0 = done_cnt;
      e0 = err_cnt;
      send(8'h3C);
      device(5, 1'b1, dev_half, fr);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      chk("rst_mid_lines", int'({tx_ready, ps2_clk_oe, ps2_data_oe}), 3'b100);
      chk("rst_mid_pulses", (done_cnt - d0) + (err_cnt - e0), 0);
      repeat (5) @(negedge clock);
      run_frame('{8'hFF, 1'b1, 1'b0, 1, 0, {1'b1, 1'b1, 8'hFF, 1'b0}}, "after_rst");

      // Device that never clocks.
      e0 = err_cnt;
      send(8'h12);
`ifdef PS2_TX_TIMEOUT_EN
      w = 0;
      while (err_cnt == e0 && w < TMO + INH + 200) begin
         @(negedge clock);
         w++;
      end
      chk("tmo_fired", err_cnt - e0, 1);
      chk("tmo_latency", err_cyc - start_cyc, TMO);
      repeat (2) @(negedge clock);
      chk("tmo_lines", int'({tx_ready, ps2_clk_oe, ps2_data_oe}), 3'b100);
`else
      repeat (INH + 500) @(negedge clock);
      chk("no_tmo_start", int'({tx_ready, ps2_clk_oe, ps2_data_oe}), 3'b001);
      chk("no_tmo_error", err_cnt - e0, 0);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      w = 0;
      chk("no_tmo_rst", int'({tx_ready, ps2_clk_oe, ps2_data_oe}), 3'b100);
`endif
      repeat (5) @(negedge clock);

      for (int i = 0; i < 8; i++) begin
         rv.data      = 8'($urandom_range(0, 255));
         rv.ack       = 1'($urandom_range(0, 1));
         rv.poke      = 1'b0;
         rv.exp_done  = rv.ack ? 1 : 0;
         rv.exp_err   = rv.ack ? 0 : 1;
         rv.exp_frame = model_frame(rv.data);
         dev_half     = int'($urandom_range(8, 14));
         run_frame(rv, $sformatf("rand%0d", i));
      end

      chk("pulse_with_ready_rise", pulse_viol, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1500000;
      $display("FAIL global_timeout: simulation did not complete, got timeout expected finish");
      $fatal(1, "global timeout");
   end

endmodule
